reg_bus_arbiter: RTL

Round-robin arbiter and transfer sequencer that shares one 8-bit bus register between N requesters. Each requester posts a read or write. The block grants the bus to one requester at a time and drives the register's write-enable and data. For a read, it captures the register output and returns a one-cycle acknowledge. It sits between the requesting units and the bus register, and it is the only agent allowed to assert the register's write-enable.

---
 rtl/reg_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that sequences one read or write at a time onto a shared bus register.
// Each transaction runs IDLE (arbitrate) -> XFER (one cycle) -> ACK (one cycle); all outputs are registered.
module reg_bus_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            Rs,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic            ack,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  input  logic [DW-1:0]   bus_q,
  output logic [DW-1:0]   bus_d,
  output logic            bus_drv,
  output logic            reg_rw
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   bus_d_q, bus_d_d;
  logic            bus_drv_q, bus_drv_d;
  logic            reg_rw_q, reg_rw_d;
  logic            busy_q, busy_d;
  logic            we_q, we_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [DW-1:0]   win_wdata;

  // Scan starts one past the last grant, so the previous winner has lowest priority.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_wdata = '0;
    for (int off = 1; off <= N; off++) begin
      cand = PW'((int'(ptr_q) + off) % N);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) win_wdata = wdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    bus_d_d   = bus_d_q;
    bus_drv_d = bus_drv_q;
    reg_rw_d  = reg_rw_q;
    busy_d    = busy_q;
    we_d      = we_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = XFER;
          ptr_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
          we_d           = we[win_idx];
          if (we[win_idx]) begin
            bus_drv_d = 1'b1;
            reg_rw_d  = 1'b1;
            bus_d_d   = win_wdata;
          end
        end
      end
      XFER: begin
        if (!we_q) rdata_d = bus_q;
        bus_drv_d = 1'b0;
        reg_rw_d  = 1'b0;
        ack_d     = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        ack_d   = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        ack_d     = 1'b0;
        bus_drv_d = 1'b0;
        reg_rw_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Rs) begin
    if (Rs) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(N - 1);
      gnt_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      bus_d_q   <= '0;
      bus_drv_q <= 1'b0;
      reg_rw_q  <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      bus_d_q   <= bus_d_d;
      bus_drv_q <= bus_drv_d;
      reg_rw_q  <= reg_rw_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign bus_d   = bus_d_q;
  assign bus_drv = bus_drv_q;
  assign reg_rw  = reg_rw_q;

endmodule
